pipe_stage_skid: RTL and testbench

//  Generic inter-stage pipeline register for the CPU pipeline (IF/ID ... ME/WB).

---
 rtl/pipe_stage_skid.sv | 137 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
//==============================================================================
// pipe_stage_skid : valid/ready pipeline register with 2-entry skid buffer
// Rev 1.0 - registered in_ready, FIFO-ordered, saturating stall/bubble counters
//==============================================================================
`default_nettype none

module pipe_stage_skid #(
    parameter int DATA_W = 96,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  bubble_cycles
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] main_q, main_nx;
    logic [DATA_W-1:0] skid_q, skid_nx;
    logic              in_fire, out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_nx = state;
        main_nx  = main_q;
        skid_nx  = skid_q;
        if (flush) begin
            state_nx = EMPTY;
            main_nx  = '0;
            skid_nx  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nx = ONE;
                        main_nx  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_nx = in_data;
                    end else if (in_fire) begin
                        state_nx = FULL;
                        skid_nx  = in_data;
                    end else if (out_fire) begin
                        state_nx = EMPTY;
                        main_nx  = '0;
                    end
                end
                FULL: begin
                    // The older entry sits in main, so skid only ever refills main
                    if (out_fire) begin
                        state_nx = ONE;
                        main_nx  = skid_q;
                        skid_nx  = '0;
                    end
                end
                default: begin
                    state_nx = EMPTY;
                    main_nx  = '0;
                    skid_nx  = '0;
                end
            endcase
        end
    end

    // Handshake outputs come straight from flops fed by the next state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            main_q    <= main_nx;
            skid_q    <= skid_nx;
            in_ready  <= (state_nx != FULL);
            out_valid <= (state_nx != EMPTY);
        end
    end

    // main is held at zero whenever the stage is empty
    assign out_data = main_q;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= '0;
        end else if (cnt_clr) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bubble_cycles <= '0;
        end else if (cnt_clr) begin
            bubble_cycles <= '0;
        end else if ((!out_valid || flush) && (bubble_cycles != '1)) begin
            bubble_cycles <= bubble_cycles + CNT_ONE;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
//==============================================================================
// tb_pipe_stage_skid : directed and random checks against a queue-based model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rstn;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic              cnt_clr;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  bubble_cycles;

    int errors = 0;
    int checks = 0;

    // Reference model: a bounded FIFO of capacity 2 plus plain integer counters
    logic [DATA_W-1:0] mq[$];
    int m_stall  = 0;
    int m_bubble = 0;

    pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .occupancy    (occupancy),
        .cnt_clr      (cnt_clr),
        .stall_cycles (stall_cycles),
        .bubble_cycles(bubble_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] exp_data();
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    // Advance one clock; the model applies the same inputs the DUT saw at the edge
    task automatic cycle();
        bit mv, mr, inf, outf;
        @(posedge clk);
        mv   = (mq.size() > 0);
        mr   = (mq.size() < 2);
        inf  = in_valid && mr;
        outf = mv && out_ready;
        if (cnt_clr) m_stall = 0;
        else if (mv && !out_ready && m_stall < CMAX) m_stall++;
        if (cnt_clr) m_bubble = 0;
        else if ((!mv || flush) && m_bubble < CMAX) m_bubble++;
        if (flush) begin
            mq.delete();
        end else begin
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back(in_data);
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 ||
            out_data !== '0 || stall_cycles !== '0 || bubble_cycles !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b occ=%0d data=%h stall=%0d bubble=%0d required 0 1 0 0 0 0",
                     out_valid, in_ready, occupancy, out_data, stall_cycles, bubble_cycles);
        end
        rstn = 1'b1;
        mq.delete(); m_stall = 0; m_bubble = 0;
    endtask

    task automatic test_basic_stream();
        in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5) begin
            errors++;
            $display("FAIL first_latency: valid=%b data=%h required 1 000000a5", out_valid, out_data);
        end
        for (int i = 1; i <= 5; i++) begin
            in_data = 32'hA5 + i;
            cycle();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 32'(32'hA5 + i)) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b ready=%b data=%h required 1 1 %h",
                         i, out_valid, in_ready, out_data, 32'(32'hA5 + i));
            end
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL stream_drain: valid=%b occ=%0d data=%h required 0 0 0", out_valid, occupancy, out_data);
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] got[$];
        int sent;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
        cycle();
        in_data = 32'h2;
        cycle();
        checks++;
        if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_data !== 32'h1) begin
            errors++;
            $display("FAIL bp_full: ready=%b occ=%0d data=%h required 0 2 00000001", in_ready, occupancy, out_data);
        end
        in_data = 32'h3;
        cycle();
        cycle();
        checks++;
        if (occupancy !== 2'd2 || out_data !== 32'h1) begin
            errors++;
            $display("FAIL bp_hold: occ=%0d data=%h required 2 00000001", occupancy, out_data);
        end
        out_ready = 1'b1;
        sent = 2;
        for (int i = 0; i < 20 && got.size() < 3; i++) begin
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_valid && in_ready) sent++;
            cycle();
            if (sent == 3) in_valid = 1'b0;
        end
        checks++;
        if (got.size() != 3 || got[0] !== 32'h1 || got[1] !== 32'h2 || got[2] !== 32'h3) begin
            errors++;
            $display("FAIL bp_order: got %0d items (%h %h %h) required 3 items 1 2 3",
                     got.size(), (got.size() > 0) ? got[0] : 'x,
                     (got.size() > 1) ? got[1] : 'x, (got.size() > 2) ? got[2] : 'x);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL bp_duplicate: valid=%b occ=%0d required 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        cycle();
        in_data = 32'h22;
        cycle();
        flush = 1'b1; in_data = 32'h9;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: occ=%0d valid=%b data=%h ready=%b required 0 0 0 1",
                     occupancy, out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_leak_%0d: valid=%b data=%h required valid 0", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_counter_saturation();
        cnt_clr = 1'b1; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
        cycle();
        cnt_clr = 1'b0;
        repeat (20) cycle();
        checks++;
        if (stall_cycles !== 4'd15 || stall_cycles !== CNT_W'(m_stall)) begin
            errors++;
            $display("FAIL stall_saturate: stall=%0d required 15", stall_cycles);
        end
        checks++;
        if (bubble_cycles !== CNT_W'(m_bubble)) begin
            errors++;
            $display("FAIL bubble_count: bubble=%0d required %0d", bubble_cycles, m_bubble);
        end
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        checks++;
        if (stall_cycles !== '0 || bubble_cycles !== '0) begin
            errors++;
            $display("FAIL cnt_clr: stall=%0d bubble=%0d required 0 0", stall_cycles, bubble_cycles);
        end
        in_valid = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++;
        if (bubble_cycles !== 4'd1 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL flush_bubble: bubble=%0d occ=%0d required 1 0", bubble_cycles, occupancy);
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int ncyc = 0;
        logic r0;
        while (sent < 10000 && ncyc < 60000) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            in_data   = $urandom;
            out_ready = 1'b0;
            flush     = ($urandom_range(0, 199) == 0);
            cnt_clr   = ($urandom_range(0, 99) < 2);
            r0 = in_ready;
            #1;
            out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== r0) begin
                errors++;
                $display("FAIL ready_comb_path cyc=%0d: in_ready moved %b->%b with out_ready", ncyc, r0, in_ready);
            end
            out_ready = ($urandom_range(0, 99) < 65);
            if (in_valid && in_ready && !flush) sent++;
            cycle();
            ncyc++;
            checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
                occupancy !== 2'(mq.size()) || out_data !== exp_data() ||
                stall_cycles !== CNT_W'(m_stall) || bubble_cycles !== CNT_W'(m_bubble)) begin
                errors++;
                $display("FAIL rand cyc=%0d: valid=%b ready=%b occ=%0d data=%h stall=%0d bubble=%0d required %b %b %0d %h %0d %0d",
                         ncyc, out_valid, in_ready, occupancy, out_data, stall_cycles, bubble_cycles,
                         mq.size() > 0, mq.size() < 2, mq.size(), exp_data(), m_stall, m_bubble);
            end
        end
        flush = 1'b0; cnt_clr = 1'b0;
        checks++;
        if (sent < 10000) begin
            errors++;
            $display("FAIL rand_budget: accepted %0d payloads required 10000", sent);
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_data = 32'hC1; out_ready = 1'b0;
        cycle();
        in_data = 32'hC2;
        cycle();
        checks++;
        if (occupancy !== 2'd2) begin
            errors++;
            $display("FAIL areset_setup: occ=%0d required 2", occupancy);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 ||
            out_data !== '0 || stall_cycles !== '0 || bubble_cycles !== '0) begin
            errors++;
            $display("FAIL async_reset: valid=%b ready=%b occ=%0d data=%h stall=%0d bubble=%0d required 0 1 0 0 0 0",
                     out_valid, in_ready, occupancy, out_data, stall_cycles, bubble_cycles);
        end
        mq.delete(); m_stall = 0; m_bubble = 0;
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        rstn = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || bubble_cycles !== CNT_W'(m_bubble)) begin
            errors++;
            $display("FAIL post_reset: valid=%b data=%h bubble=%0d required 0 0 %0d",
                     out_valid, out_data, bubble_cycles, m_bubble);
        end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_flush();
        test_counter_saturation();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
